// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   fetch_entry_t : one queued fetch, {pc, inst}
//   INST_BYTES    : fetch stride in bytes
//   NOP_INST      : canonical NOP encoding (addi x0, x0, 0)
package fetch_queue_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of fetch entries.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset (pointers and count)
//   push, push_data - write push_data at the tail
//   pop             - drop the head (caller guarantees count != 0)
//   flush           - clear all entries; overrides push and pop
//   head            - entry at the read pointer
//   count           - number of valid entries
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointer/count bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetcher feeding the IF/ID register
// through a small queue, with branch redirect flush.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (present an arriving response
// directly when the queue is empty).
// Ports:
//   clk, reset                - clock, asynchronous active-low reset
//   imem_req, imem_addr       - fetch request and byte address (= fetch_pc)
//   imem_rdata                - instruction, valid one cycle after the request
//   redirect_valid/pc         - flush and refetch from redirect_pc (word aligned)
//   out_valid/ready/pc/inst   - head entry handshake toward decode
//   occupancy                 - entries stored in the queue
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH    = 4,
  parameter  logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1),
  localparam int unsigned SUM_W    = CNT_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [CNT_W-1:0] occupancy
);

  logic         started;
  logic [31:0]  fetch_pc;
  logic         inflight;
  logic [31:0]  inflight_pc;
  logic [31:0]  last_pc;
  logic [31:0]  last_inst;
  fetch_entry_t head;
  fetch_entry_t push_data;
  logic         fifo_empty;
  logic [SUM_W-1:0] pending;
  logic         resp_ok;
  logic         bypass;
  logic         push;
  logic         pop;
  logic         unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign imem_addr = fetch_pc;

  // Request gating, response steering and head presentation.
  always_comb begin
    fifo_empty = (occupancy == '0);
    pending    = SUM_W'(occupancy) + SUM_W'(inflight);
    imem_req   = started && !redirect_valid && (pending < SUM_W'(DEPTH));
    resp_ok    = inflight && !redirect_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass     = resp_ok && fifo_empty;
`else
    bypass     = 1'b0;
`endif
    out_valid  = !redirect_valid && (!fifo_empty || bypass);
    if (!fifo_empty) begin
      out_pc   = head.pc;
      out_inst = head.inst;
    end else if (bypass) begin
      out_pc   = inflight_pc;
      out_inst = imem_rdata;
    end else begin
      out_pc   = last_pc;
      out_inst = last_inst;
    end
    pop            = out_valid && out_ready && !fifo_empty;
    push           = resp_ok && !(bypass && out_ready);
    push_data.pc   = inflight_pc;
    push_data.inst = imem_rdata;
  end

  // Fetch PC, inflight tracking and hold of the last presented head.
  // started delays the first request to the cycle after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      last_pc     <= '0;
      last_inst   <= '0;
    end else begin
      started   <= 1'b1;
      inflight  <= imem_req;
      last_pc   <= out_pc;
      last_inst <= out_inst;
      if (imem_req) inflight_pc <= fetch_pc;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + 32'(INST_BYTES);
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (occupancy)
  );

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory this cycle.
REQ-006 imem_addr  output  32  byte address of the request; always equals the internal fetch_pc.
REQ-007 imem_rdata  input  32  instruction word, valid exactly one cycle after its imem_req.
REQ-008 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-009 redirect_pc  input  32  new fetch address, sampled when redirect_valid=1.
REQ-010 out_valid  output  1  head entry is available to the IF/ID register.
REQ-011 out_ready  input  1  IF/ID accepts the head this cycle.
REQ-012 out_pc  output  32  PC of head entry.
REQ-013 out_inst  output  32  instruction of head entry.
REQ-014 occupancy  output  $clog2(DEPTH+1)  valid entries currently stored.

Function
REQ-015 A transfer occurs when out_valid and out_ready are both 1; the head is popped at that edge.
REQ-016 imem_req SHALL be 1 iff redirect_valid=0 and occupancy + inflight < DEPTH, where inflight is 1 when a request was issued last cycle and not killed.
REQ-017 On each issued request, fetch_pc advances by 4 modulo 2^32, and the request PC is held for one cycle as inflight_pc.
REQ-018 One cycle after a non-killed request, {inflight_pc, imem_rdata} is written to the tail entry.
REQ-019 Simultaneous push and pop leaves occupancy unchanged; read and write pointers wrap modulo DEPTH.
REQ-020 The queue never overflows; a push into a full queue is unreachable by REQ-016.
REQ-021 While empty, out_valid=0 and out_pc/out_inst hold their last values; out_ready is ignored.
REQ-022 With redirect_valid=1: out_valid forced 0, no pop, no request, all entries cleared, any inflight response discarded, fetch_pc loaded with {redirect_pc[31:2],2'b00}.
REQ-023 Redirect latency: redirect at cycle N, request to the new PC at N+1, entry written at end of N+2, out_valid=1 at N+3.
REQ-024 Redirects on consecutive cycles are each honoured; the last one wins.
REQ-025 Steady-state throughput with out_ready held at 1 is one instruction per cycle.

Reset
REQ-026 While reset=0: fetch_pc=RESET_PC, occupancy=0, pointers=0, inflight=0, imem_req=0, out_valid=0, out_pc=0, out_inst=0.
REQ-027 The first request, to RESET_PC, is issued in the first cycle after reset deasserts.
REQ-028 Reset asserted mid-operation discards all entries and inflight responses immediately.

Configuration
REQ-029 Macro FETCH_QUEUE_BYPASS_EN, when defined, passes an arriving response straight to out_pc/out_inst with out_valid=1 in the same cycle if the queue is empty; when out_ready=1 that response is not stored.
REQ-030 With FETCH_QUEUE_BYPASS_EN, redirect-to-out_valid latency is 2 cycles; without it, 3 cycles, and every response is stored before it is presented.

Structure
REQ-031 A shared package holds the fetch_entry_t typedef {pc[31:0], inst[31:0]}, the INST_BYTES=4 constant, and the NOP encoding 32'h0000_0013.
REQ-032 Storage is one sub-module, fetch_fifo: DEPTH entries with push, pop, flush, count, and an asynchronous active-low reset.

Verification
REQ-033 Reset release, out_ready=1, memory returns addr+32'h100 -> imem_addr 0,4,8,...; out_pc 0,4,8 with out_inst 0x100,0x104,0x108, from cycle 3 (cycle 2 with bypass).
REQ-034 out_ready=0 for 10 cycles -> occupancy saturates at 4, imem_req=0 while full; on release, PCs 0..C appear in order with no loss or duplicate.
REQ-035 redirect_valid=1, redirect_pc=0x80 while 3 entries are queued and one is inflight -> next transfer is pc=0x80; no old PC appears.
REQ-036 redirect_pc=0x83 -> first fetch address is 0x80.
REQ-037 fetch_pc=0xFFFF_FFFC without stalls -> next request address is 0x0000_0000.
REQ-038 reset pulsed low for half a cycle while full -> occupancy=0 and out_valid=0 immediately; refetch starts at RESET_PC.
